morse_input_ctrl: RTL

- Front-end controller between the four raw Morse push-buttons (dot, dash, char space, word space) and the character decoder/display path inside morse_top.
- Synchronises and debounces each button and turns presses into single-cycle events.
- Accumulates dot/dash symbols into a code word and issues CHAR/SPACE/ERR tokens to the decoder over a valid/ready handshake, so the decoder never sees raw button activity.

---
 rtl/morse_pkg.sv | 22 ++
 rtl/morse_input_ctrl_if.sv | 13 +
 rtl/morse_btn_cond.sv | 43 ++++
 rtl/morse_input_ctrl.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse button front-end.
package morse_pkg;

  localparam int MAX_SYM_DEF = 6;
  localparam int LEN_W       = 3;
  localparam int KIND_W      = 2;

  typedef enum logic [KIND_W-1:0] {
    TOK_CHAR  = 2'd0,
    TOK_SPACE = 2'd1,
    TOK_ERR   = 2'd2
  } tok_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_OVERFLOW,
    ST_EMIT_CHAR,
    ST_EMIT_SPACE
  } state_e;

endpackage

// File: rtl/morse_input_ctrl_if.sv
// Token channel from the button front-end to the character decoder.
interface morse_input_ctrl_if #(parameter int MAX_SYM = morse_pkg::MAX_SYM_DEF);
  import morse_pkg::*;

  logic                 tok_valid;
  logic                 tok_ready;
  tok_kind_e            tok_kind;
  logic [LEN_W-1:0]     tok_len;
  logic [MAX_SYM-1:0]   tok_bits;

  modport master (output tok_valid, tok_kind, tok_len, tok_bits, input tok_ready);
  modport slave  (input tok_valid, tok_kind, tok_len, tok_bits, output tok_ready);
endinterface

// File: rtl/morse_btn_cond.sv
// Per-button synchroniser, debouncer and rising-edge event pulse.
// Press to evt takes SYNC_STAGES+DEBOUNCE_CYC cycles; free-running, no backpressure.
module morse_btn_cond #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic evt
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   mismatch;
  logic                   flip;

  assign mismatch = sync_q[SYNC_STAGES-1] != level_q;
  assign flip     = mismatch && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      evt     <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
      // Only the debounced rising edge is an event; releases are silent.
      evt    <= flip && !level_q;
      if (flip) begin
        level_q <= ~level_q;
        cnt_q   <= '0;
      end else if (mismatch) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        cnt_q <= '0;
      end
    end
  end
endmodule

// File: rtl/morse_input_ctrl.sv
// Turns debounced Morse button events into CHAR/SPACE/ERR tokens on a valid/ready channel.
// Terminating event to tok_valid is one cycle; tok_* hold while tok_ready is low and events are dropped while busy.
module morse_input_ctrl
  import morse_pkg::*;
#(
  parameter int MAX_SYM      = MAX_SYM_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dot_inp,
  input  logic               dash_inp,
  input  logic               char_space_inp,
  input  logic               word_space_inp,
  morse_input_ctrl_if.master tok,
  output logic [LEN_W-1:0]   sym_count,
  output logic               busy
);
  logic [3:0] raw;
  logic [3:0] evt;

  assign raw = {word_space_inp, char_space_inp, dash_inp, dot_inp};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    morse_btn_cond #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_cond (
      .clk (clk),
      .rst (rst),
      .raw (raw[i]),
      .evt (evt[i])
    );
  end

  logic ev_word, ev_char, ev_sym, sym_val;
  assign ev_word = evt[3];
  assign ev_char = evt[2];
  assign ev_sym  = evt[1] | evt[0];
  assign sym_val = evt[1];

  state_e               state_q, state_d;
  logic [MAX_SYM-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 err_q, err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      err_q   <= err_d;
    end
  end

  // The if/else ordering inside each state is the event priority: word > char > dash > dot.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (ev_word) begin
          state_d = ST_EMIT_SPACE;
        end else if (ev_char) begin
          state_d = ST_IDLE;
        end else if (ev_sym) begin
          acc_d   = MAX_SYM'(sym_val);
          cnt_d   = LEN_W'(1);
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (ev_word) begin
          pend_d  = 1'b1;
          state_d = ST_EMIT_CHAR;
        end else if (ev_char) begin
          state_d = ST_EMIT_CHAR;
        end else if (ev_sym) begin
          if (cnt_q == LEN_W'(MAX_SYM)) begin
            err_d   = 1'b1;
            state_d = ST_OVERFLOW;
          end else begin
            acc_d = acc_q | (MAX_SYM'(sym_val) << cnt_q);
            cnt_d = cnt_q + LEN_W'(1);
          end
        end
      end
      ST_OVERFLOW: begin
        if (ev_word) begin
          pend_d  = 1'b1;
          state_d = ST_EMIT_CHAR;
        end else if (ev_char) begin
          state_d = ST_EMIT_CHAR;
        end
      end
      ST_EMIT_CHAR: begin
        if (tok.tok_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = pend_q ? ST_EMIT_SPACE : ST_IDLE;
        end
      end
      ST_EMIT_SPACE: begin
        if (tok.tok_ready) begin
          pend_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs come straight from registered state, so they cannot move during a stall.
  always_comb begin
    tok.tok_valid = 1'b0;
    tok.tok_kind  = TOK_CHAR;
    tok.tok_len   = '0;
    tok.tok_bits  = '0;
    if (state_q == ST_EMIT_CHAR) begin
      tok.tok_valid = 1'b1;
      if (err_q) begin
        tok.tok_kind = TOK_ERR;
      end else begin
        tok.tok_len  = cnt_q;
        tok.tok_bits = acc_q;
      end
    end else if (state_q == ST_EMIT_SPACE) begin
      tok.tok_valid = 1'b1;
      tok.tok_kind  = TOK_SPACE;
    end
  end

  assign sym_count = cnt_q;
  assign busy      = (state_q == ST_EMIT_CHAR) || (state_q == ST_EMIT_SPACE);
endmodule
